// File: rtl/my_32bit1to8_route_reg.sv
// 1-to-8 registered word router with per-lane valid/ack backpressure.
// Optional same-cycle lane refill on ack: define MY_ROUTE_REG_REFILL_EN.
module my_32bit1to8_route_reg (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic [2:0]   select_signal,
    output logic [255:0] out_data,
    output logic [7:0]   out_valid,
    input  logic [7:0]   out_ack,
    output logic [3:0]   occupancy,
    output logic [15:0]  accept_count
);

    localparam logic [0:0] LANE_EMPTY = 1'b0;
    localparam logic [0:0] LANE_FULL  = 1'b1;

    logic [7:0]  state_q;
    logic [7:0]  state_d;
    logic [31:0] data_q [8];
    logic [31:0] data_d [8];
    logic [3:0]  occ_q;
    logic [3:0]  occ_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    logic        accept;
    logic [7:0]  hit;
    logic [7:0]  rel;
    logic [3:0]  rel_cnt;

    always_comb begin
`ifdef MY_ROUTE_REG_REFILL_EN
        in_ready = !reset &&
                   ((state_q[select_signal] == LANE_EMPTY) ||
                    out_ack[select_signal]);
`else
        in_ready = !reset &&
                   (state_q[select_signal] == LANE_EMPTY);
`endif
    end

    assign accept = in_valid & in_ready;
    assign hit    = accept ? (8'd1 << select_signal) : 8'd0;
    assign rel    = out_ack & state_q;

    // A write wins over a release so a refill keeps the lane full.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            state_d[i] = state_q[i];
            data_d[i]  = data_q[i];
            priority case (1'b1)
                hit[i]: begin
                    state_d[i] = LANE_FULL;
                    data_d[i]  = in_data;
                end
                rel[i]: state_d[i] = LANE_EMPTY;
                default: ;
            endcase
        end
    end

    always_comb begin
        rel_cnt = '0;
        for (int i = 0; i < 8; i++) begin
            rel_cnt = rel_cnt + 4'(rel[i]);
        end
    end

    assign occ_d = occ_q + 4'(accept) - rel_cnt;
    assign cnt_d = cnt_q + 16'(accept);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= '0;
            occ_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < 8; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < 8; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < 8; i++) begin
            out_data[32*i +: 32] = data_q[i];
        end
    end

    assign out_valid    = state_q;
    assign occupancy    = occ_q;
    assign accept_count = cnt_q;

endmodule

// File: tb/tb_my_32bit1to8_route_reg.sv
// Directed self-checking bench for my_32bit1to8_route_reg.
// Expected values are hand-computed per step.
module tb_my_32bit1to8_route_reg;

    logic         clock;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic [2:0]   select_signal;
    logic [255:0] out_data;
    logic [7:0]   out_valid;
    logic [7:0]   out_ack;
    logic [3:0]   occupancy;
    logic [15:0]  accept_count;

    int checks;
    int failures;

    my_32bit1to8_route_reg dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .select_signal (select_signal),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ack       (out_ack),
        .occupancy     (occupancy),
        .accept_count  (accept_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [255:0] obs,
                         input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane(input int i);
        return out_data[32*i +: 32];
    endfunction

    initial begin
        int pump_bad;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hAAAA5555;
        select_signal = 3'd0;
        out_ack  = 8'h00;

        // Reset for two cycles with a request presented
        tick();
        tick();
        check("rst_valid", 256'(out_valid), 256'h00);
        check("rst_data", out_data, 256'h0);
        check("rst_occ", 256'(occupancy), 256'h0);
        check("rst_cnt", 256'(accept_count), 256'h0);
        check("rst_ready", 256'(in_ready), 256'h0);

        reset = 1'b0;
        #1;
        check("post_rst_ready", 256'(in_ready), 256'h1);
        tick();
        check("first_valid", 256'(out_valid), 256'h01);
        check("first_lane0", 256'(lane(0)), 256'hAAAA5555);
        check("first_cnt", 256'(accept_count), 256'h1);

        // Single route to lane 5 while releasing lane 0
        in_data = 32'hDEADBEEF;
        select_signal = 3'd5;
        out_ack = 8'h01;
        tick();
        check("route_valid", 256'(out_valid), 256'h20);
        check("route_lane5", 256'(lane(5)), 256'hDEADBEEF);
        check("route_occ", 256'(occupancy), 256'h1);
        check("route_cnt", 256'(accept_count), 256'h2);
        check("route_lane0_kept", 256'(lane(0)), 256'hAAAA5555);

        // Fill lane 3
        in_data = 32'h33333333;
        select_signal = 3'd3;
        out_ack = 8'h00;
        tick();
        check("l3_valid", 256'(out_valid), 256'h28);
        check("l3_occ", 256'(occupancy), 256'h2);

        // Stall on full lane 3
        in_data = 32'h44444444;
        #1;
        check("stall_ready", 256'(in_ready), 256'h0);
        tick();
        check("stall_valid", 256'(out_valid), 256'h28);
        check("stall_lane3", 256'(lane(3)), 256'h33333333);
        check("stall_cnt", 256'(accept_count), 256'h3);

        out_ack = 8'h08;
        #1;
`ifdef MY_ROUTE_REG_REFILL_EN
        check("ack_ready", 256'(in_ready), 256'h1);
        tick();
        out_ack = 8'h00;
        in_valid = 1'b0;
`else
        check("ack_ready", 256'(in_ready), 256'h0);
        tick();
        check("bubble_valid", 256'(out_valid), 256'h20);
        check("bubble_lane3", 256'(lane(3)), 256'h33333333);
        check("bubble_occ", 256'(occupancy), 256'h1);
        out_ack = 8'h00;
        #1;
        check("bubble_ready", 256'(in_ready), 256'h1);
        tick();
        in_valid = 1'b0;
`endif
        check("refill_valid", 256'(out_valid), 256'h28);
        check("refill_lane3", 256'(lane(3)), 256'h44444444);
        check("refill_occ", 256'(occupancy), 256'h2);
        check("refill_cnt", 256'(accept_count), 256'h4);

        out_ack = 8'hFF;
        tick();
        check("drain_valid", 256'(out_valid), 256'h00);
        check("drain_occ", 256'(occupancy), 256'h0);

        // Fill all lanes back to back
        out_ack = 8'h00;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            select_signal = 3'(i);
            in_data = 32'h10 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        check("fill_valid", 256'(out_valid), 256'hFF);
        check("fill_occ", 256'(occupancy), 256'h8);
        check("fill_cnt", 256'(accept_count), 256'd12);

        out_ack = 8'hFF;
        tick();
        check("ackall_valid", 256'(out_valid), 256'h00);
        check("ackall_occ", 256'(occupancy), 256'h0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ackall_lane%0d", i),
                  256'(lane(i)), 256'h10 + 256'(i));
        end

        // Simultaneous accept and multi-lane release
        out_ack = 8'h00;
        in_valid = 1'b1;
        select_signal = 3'd0;
        in_data = 32'hA0;
        tick();
        select_signal = 3'd2;
        in_data = 32'hA2;
        tick();
        check("pre_sim_valid", 256'(out_valid), 256'h05);
        select_signal = 3'd1;
        in_data = 32'hA1;
        out_ack = 8'h05;
        tick();
        check("sim_valid", 256'(out_valid), 256'h02);
        check("sim_occ", 256'(occupancy), 256'h1);
        check("sim_lane1", 256'(lane(1)), 256'hA1);
        check("sim_cnt", 256'(accept_count), 256'd15);

        in_valid = 1'b0;
        out_ack = 8'h40;
        tick();
        check("emptyack_valid", 256'(out_valid), 256'h02);
        check("emptyack_occ", 256'(occupancy), 256'h1);
        check("emptyack_cnt", 256'(accept_count), 256'd15);

        // Reset mid-operation with pending ack and request
        reset = 1'b1;
        in_valid = 1'b1;
        select_signal = 3'd4;
        out_ack = 8'h02;
        #1;
        check("midrst_ready", 256'(in_ready), 256'h0);
        tick();
        check("midrst_valid", 256'(out_valid), 256'h00);
        check("midrst_data", out_data, 256'h0);
        check("midrst_occ", 256'(occupancy), 256'h0);
        check("midrst_cnt", 256'(accept_count), 256'h0);

        // Counter wrap: 65535 accepts, then one more
        reset = 1'b0;
        out_ack = 8'hFF;
        in_valid = 1'b1;
        pump_bad = 0;
        for (int i = 0; i < 65535; i++) begin
            select_signal = 3'(i);
            in_data = 32'(i);
            #1;
            if (in_ready !== 1'b1) pump_bad++;
            tick();
        end
        check("pump_stalls", 256'(pump_bad), 256'h0);
        check("cnt_ffff", 256'(accept_count), 256'hFFFF);
        select_signal = 3'd7;
        tick();
        in_valid = 1'b0;
        check("cnt_wrap", 256'(accept_count), 256'h0000);
        check("wrap_occ", 256'(occupancy), 256'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
